// File: rtl/dmem_pkg.sv
// Shared types for the CPU data-memory request/response interface.
// The MEM stage builds DMemReq_t and consumes DMemRsp_t.
package dmem_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0001_0000;
    localparam int          DMEM_ADDR_WIDTH  = 12;
    localparam int          DMEM_WAIT_STATES = 1;

    typedef struct packed {
        logic        Write;
        logic [31:0] Addr;
        logic [31:0] WData;
        logic [3:0]  ByteEn;
    } DMemReq_t;

    typedef struct packed {
        logic [31:0] RData;
        logic        Error;
    } DMemRsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } DMemState_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, 1-cycle read.
// Read-first: a write cycle returns the old word, which the responder discards for stores.
module dmem_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_Clock,
    input  logic                  i_En,
    input  logic [3:0]            i_WrEn,
    input  logic [ADDR_WIDTH-1:0] i_Addr,
    input  logic [31:0]           i_WData,
    output logic [31:0]           o_RData
);

    logic [31:0] r_Mem [2**ADDR_WIDTH];
    logic [31:0] r_RData;

    always_ff @(posedge i_Clock) begin
        if (i_En) begin
            for (int b = 0; b < 4; b++) begin
                if (i_WrEn[b]) begin
                    r_Mem[i_Addr][8*b +: 8] <= i_WData[8*b +: 8];
                end
            end
            r_RData <= r_Mem[i_Addr];
        end
    end

    assign o_RData = r_RData;

endmodule

// File: rtl/data_memory_responder.sv
// Data-side memory responder: accepts one request, waits WAIT_STATES cycles,
// commits the RAM access on the edge entering RESP, then holds the response until taken.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          WAIT_STATES = DMEM_WAIT_STATES
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_ReqValid,
    output logic        o_ReqReady,
    input  logic        i_ReqWrite,
    input  logic [31:0] i_ReqAddr,
    input  logic [31:0] i_ReqWData,
    input  logic [3:0]  i_ReqByteEn,
    output logic        o_RspValid,
    input  logic        i_RspReady,
    output logic [31:0] o_RspRData,
    output logic        o_RspError,
    output DMemState_t  o_DbgState
);

    // Handshakes: a request transfers on a rising edge where i_ReqValid && o_ReqReady;
    // a response transfers on a rising edge where o_RspValid && i_RspReady.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    DMemState_t            r_State;
    DMemState_t            w_NextState;
    logic [3:0]            r_Count;
    DMemReq_t              r_Req;
    logic                  r_RspError;
    logic                  r_RspLoad;

    DMemReq_t              w_InReq;
    DMemReq_t              w_CommitReq;
    DMemRsp_t              w_Rsp;
    logic                  w_Accept;
    logic                  w_Commit;
    logic                  w_Fault;
    logic [31:0]           w_Offset;
    logic [ADDR_WIDTH-1:0] w_WordIdx;
    logic                  w_RamEn;
    logic [3:0]            w_RamWe;
    logic [31:0]           w_RamQ;

    always_comb begin
        w_InReq        = '0;
        w_InReq.Write  = i_ReqWrite;
        w_InReq.Addr   = i_ReqAddr;
        w_InReq.WData  = i_ReqWData;
        w_InReq.ByteEn = i_ReqByteEn;
    end

    assign o_ReqReady = (r_State == IDLE) && !i_Reset;
    assign w_Accept   = i_ReqValid && o_ReqReady;

    always_comb begin
        w_NextState = r_State;
        w_Commit    = 1'b0;
        case (r_State)
            IDLE: begin
                if (w_Accept) begin
                    if (WAIT_STATES == 0) begin
                        w_NextState = RESP;
                        w_Commit    = 1'b1;
                    end else begin
                        w_NextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_Count == 4'd0) begin
                    w_NextState = RESP;
                    w_Commit    = 1'b1;
                end
            end
            RESP: begin
                if (i_RspReady) begin
                    w_NextState = IDLE;
                end
            end
            default: w_NextState = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accept edge, before the latch holds the request.
    assign w_CommitReq = (r_State == IDLE) ? w_InReq : r_Req;

    // BASE_ADDR is aligned to the RAM size, so the offset's low bits mirror the address's low bits;
    // the subtraction wraps for addresses below the base, which then fail the range test.
    assign w_Offset  = w_CommitReq.Addr - BASE_ADDR;
    assign w_Fault   = (w_Offset[1:0] != 2'b00) || (|w_Offset[31:ADDR_WIDTH+2]);
    assign w_WordIdx = w_Offset[ADDR_WIDTH+1:2];
    assign w_RamEn   = w_Commit && !w_Fault;
    assign w_RamWe   = w_CommitReq.Write ? w_CommitReq.ByteEn : 4'b0000;

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_Clock(i_Clock),
        .i_En   (w_RamEn),
        .i_WrEn (w_RamWe),
        .i_Addr (w_WordIdx),
        .i_WData(w_CommitReq.WData),
        .o_RData(w_RamQ)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State    <= IDLE;
            r_Count    <= 4'd0;
            r_Req      <= '0;
            r_RspError <= 1'b0;
            r_RspLoad  <= 1'b0;
        end else begin
            r_State <= w_NextState;
            if (w_Accept) begin
                r_Req   <= w_InReq;
                r_Count <= WAIT_LOAD;
            end else if ((r_State == WAIT) && (r_Count != 4'd0)) begin
                r_Count <= r_Count - 4'd1;
            end
            if (w_Commit) begin
                r_RspError <= w_Fault;
                r_RspLoad  <= !w_CommitReq.Write && !w_Fault;
            end
        end
    end

    // The RAM output only changes on a commit edge, so it stays stable for the whole RESP hold.
    always_comb begin
        w_Rsp       = '0;
        w_Rsp.Error = (r_State == RESP) && r_RspError;
        w_Rsp.RData = ((r_State == RESP) && r_RspLoad) ? w_RamQ : 32'd0;
    end

    assign o_RspValid = (r_State == RESP);
    assign o_RspRData = w_Rsp.RData;
    assign o_RspError = w_Rsp.Error;
    assign o_DbgState = r_State;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (WAIT_STATES 1, 0, 15) driven by
// directed scenarios and random traffic, checked against an associative-array memory model.
module tb_data_memory_responder;
    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_write [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_be    [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_error [NDUT];
    DMemState_t  dbg_state [NDUT];

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [int];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_memory_responder #(
            .ADDR_WIDTH (12),
            .BASE_ADDR  (BASE),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 15))
        ) u_dut (
            .i_Clock    (clk),
            .i_Reset    (rst),
            .i_ReqValid (req_valid[g]),
            .o_ReqReady (req_ready[g]),
            .i_ReqWrite (req_write[g]),
            .i_ReqAddr  (req_addr[g]),
            .i_ReqWData (req_wdata[g]),
            .i_ReqByteEn(req_be[g]),
            .o_RspValid (rsp_valid[g]),
            .i_RspReady (rsp_ready[g]),
            .o_RspRData (rsp_rdata[g]),
            .o_RspError (rsp_error[g]),
            .o_DbgState (dbg_state[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
    endfunction

    // Reference: 4096-word memory per instance at BASE; faults leave memory untouched.
    function automatic void ref_txn(input int d, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output logic [31:0] exp_rdata, output logic exp_err,
                                    output bit known);
        logic [31:0] off;
        logic [31:0] word;
        int          key;
        off       = addr - BASE;
        exp_rdata = 32'd0;
        known     = 1'b1;
        exp_err   = ((addr % 4) != 0) || ((off / 4) >= 32'd4096);
        if (exp_err) return;
        key = d * 4096 + int'(off / 4);
        if (wr) begin
            if (ref_mem.exists(key) || be == 4'hF) begin
                word = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
                end
                ref_mem[key] = word;
            end
        end else if (ref_mem.exists(key)) begin
            exp_rdata = ref_mem[key];
        end else begin
            known = 1'b0;
        end
    endfunction

    // Driver: issue one request, measure latency in cycles from the handshake cycle, optionally
    // stall the response and optionally keep a second request pending while the first is in flight.
    task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int stall, input bit pend,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output bit held_ok, output bit ready_back);
        int guard;
        held_ok    = 1'b1;
        ready_back = 1'b0;
        lat        = -1;
        rdata      = 32'hxxxx_xxxx;
        err        = 1'bx;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        lat = 1;
        req_valid[d] = pend;
        if (pend) begin
            req_write[d] = 1'b0;
            req_addr[d]  = BASE;
        end
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid[d] !== 1'b1) begin
            lat = -1;
            req_valid[d] = 1'b0;
            return;
        end
        rdata = rsp_rdata[d];
        err   = rsp_error[d];
        if (req_ready[d] !== 1'b0) held_ok = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rdata || rsp_error[d] !== err ||
                req_ready[d] !== 1'b0) held_ok = 1'b0;
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        ready_back   = (req_ready[d] === 1'b1) && (rsp_valid[d] === 1'b0);
        req_valid[d] = 1'b0;
    endtask

    task automatic xact(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int stall, input bit pend,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output bit held_ok, output bit ready_back);
        logic [31:0] er;
        logic        ee;
        bit          kn;
        ref_txn(d, wr, addr, wdata, be, er, ee, kn);
        do_txn(d, wr, addr, wdata, be, stall, pend, rdata, err, lat, held_ok, ready_back);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_be[d]    = 4'd0;
            rsp_ready[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 ||
                rsp_error[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got ready=%b valid=%b rdata=%h err=%b expected 0 0 00000000 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_error[d]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || dbg_state[d] !== IDLE) begin
                failures++;
                $display("FAIL reset_release dut%0d: got ready=%b state=%0d expected ready=1 state=%0d",
                         d, req_ready[d], dbg_state[d], IDLE);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        xact(0, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b0 || rd !== 32'd0 || lat != 2) begin
            failures++;
            $display("FAIL store_full: got err=%b rdata=%h lat=%0d expected 0 00000000 2", er, rd, lat);
        end
        xact(0, 1'b0, 32'h0001_0010, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAD_BEEF || lat != 2 || !rb) begin
            failures++;
            $display("FAIL load_full: got err=%b rdata=%h lat=%0d ready_back=%0d expected 0 deadbeef 2 1",
                     er, rd, lat, rb);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        xact(0, 1'b1, 32'h0001_0010, 32'h0000_00AA, 4'b0001, 0, 1'b0, rd, er, lat, held, rb);
        xact(0, 1'b0, 32'h0001_0010, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAD_BEAA) begin
            failures++;
            $display("FAIL byte_lane0: got err=%b rdata=%h expected 0 deadbeaa", er, rd);
        end
        xact(0, 1'b1, 32'h0001_0010, 32'h1234_5678, 4'b0000, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b0 || rd !== 32'd0) begin
            failures++;
            $display("FAIL store_be0: got err=%b rdata=%h expected 0 00000000", er, rd);
        end
        xact(0, 1'b0, 32'h0001_0010, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (rd !== 32'hDEAD_BEAA) begin
            failures++;
            $display("FAIL load_after_be0: got rdata=%h expected deadbeaa", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        xact(0, 1'b1, BASE, 32'hCAFE_F00D, 4'hF, 0, 1'b0, rd, er, lat, held, rb);
        xact(0, 1'b0, 32'h0001_0002, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != 2) begin
            failures++;
            $display("FAIL err_misaligned: got err=%b rdata=%h lat=%0d expected 1 00000000 2", er, rd, lat);
        end
        xact(0, 1'b1, 32'h0001_4000, 32'h5555_5555, 4'hF, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_above_range: got err=%b rdata=%h expected 1 00000000", er, rd);
        end
        xact(0, 1'b0, BASE, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL word0_untouched: got err=%b rdata=%h expected 0 cafef00d", er, rd);
        end
        xact(0, 1'b0, 32'h0000_FFFC, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_below_base: got err=%b rdata=%h expected 1 00000000", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        xact(0, 1'b0, 32'h0001_0010, 32'd0, 4'h0, 5, 1'b1, rd, er, lat, held, rb);
        checks++;
        if (!held || !rb || rd !== 32'hDEAD_BEAA || lat != 2) begin
            failures++;
            $display("FAIL backpressure: got held=%0d ready_back=%0d rdata=%h lat=%0d expected 1 1 deadbeaa 2",
                     held, rb, rd, lat);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        for (int d = 1; d < NDUT; d++) begin
            xact(d, 1'b1, 32'h0001_0010, 32'h0BAD_F00D + 32'(d), 4'hF, 0, 1'b0, rd, er, lat, held, rb);
            xact(d, 1'b0, 32'h0001_0010, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
            checks++;
            if (lat != ws_of(d) + 1 || rd !== 32'h0BAD_F00D + 32'(d) || er !== 1'b0) begin
                failures++;
                $display("FAIL latency dut%0d: got lat=%0d rdata=%h err=%b expected %0d %h 0",
                         d, lat, rd, er, ws_of(d) + 1, 32'h0BAD_F00D + 32'(d));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic wr;
        logic [31:0] er_d; logic ee; bit kn;
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        logic [32:0] exp;
        int kind; int idx; int stall;
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 46; n++) begin
                idx   = $urandom_range(0, 15);
                stall = $urandom_range(0, 3);
                if (n < 16) begin
                    addr = BASE + 32'h100 + 32'(n * 4);
                    wr = 1'b1; be = 4'hF; wdata = $urandom;
                end else begin
                    kind  = $urandom_range(0, 9);
                    wr    = 1'($urandom_range(0, 1));
                    be    = 4'($urandom_range(0, 15));
                    wdata = $urandom;
                    addr  = BASE + 32'h100 + 32'(idx * 4);
                    if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
                    else if (kind == 1) addr = BASE + 32'h4000 + 32'(idx * 4);
                    else if (kind == 2) addr = BASE - 32'((idx + 1) * 4);
                end
                ref_txn(d, wr, addr, wdata, be, er_d, ee, kn);
                exp_q.push_back({ee, er_d});
                do_txn(d, wr, addr, wdata, be, stall, 1'b0, rd, er, lat, held, rb);
                exp = exp_q.pop_front();
                checks++;
                if (er !== exp[32] || (kn && rd !== exp[31:0]) || lat != ws_of(d) + 1 || !held || !rb) begin
                    failures++;
                    $display("FAIL random dut%0d n=%0d addr=%h wr=%b: got err=%b rdata=%h lat=%0d held=%0d rb=%0d expected err=%b rdata=%h lat=%0d",
                             d, n, addr, wr, er, rd, lat, held, rb, exp[32], exp[31:0], ws_of(d) + 1);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic er; int lat; bit held; bit rb;
        xact(2, 1'b1, 32'h0001_0020, 32'hA5A5_1234, 4'hF, 0, 1'b0, rd, er, lat, held, rb);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h0001_0020;
        req_wdata[2] = 32'hFFFF_0000;
        req_be[2]    = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state[2] !== WAIT) begin
            failures++;
            $display("FAIL in_wait_before_reset: got state=%0d expected %0d", dbg_state[2], WAIT);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dbg_state[2] !== IDLE || rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0 ||
            rsp_rdata[2] !== 32'd0 || rsp_error[2] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got state=%0d valid=%b ready=%b rdata=%h err=%b expected %0d 0 0 00000000 0",
                     dbg_state[2], rsp_valid[2], req_ready[2], rsp_rdata[2], rsp_error[2], IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready[2] !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b expected 1", req_ready[2]);
        end
        @(negedge clk);
        xact(2, 1'b0, 32'h0001_0020, 32'd0, 4'h0, 0, 1'b0, rd, er, lat, held, rb);
        checks++;
        if (rd !== 32'hA5A5_1234 || er !== 1'b0) begin
            failures++;
            $display("FAIL dropped_store: got rdata=%h err=%b expected a5a51234 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_latency();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
